// File: rtl/video_frame_monitor.sv
// video_frame_monitor: checks frame geometry (pixels per line, lines per
// frame) of a vs/de/data video stream, flags de outside the frame window,
// counts frames and optionally accumulates a per-frame pixel checksum.
// Results are reported once per frame with a one-cycle frame_done strobe.
// Optional feature macro: VFM_CHECKSUM_EN (builds the checksum accumulator;
// when undefined frame_checksum is tied to 0).
module video_frame_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 720
) (
  input  logic                  video_clk,
  input  logic                  rst,
  input  logic                  video_vs,
  input  logic                  video_de,
  input  logic [DATA_WIDTH-1:0] video_data,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  err_width,
  output logic                  err_height,
  output logic                  err_stray,
  output logic [11:0]           line_count,
  output logic [11:0]           bad_line_width,
  output logic [15:0]           frame_count,
  output logic [31:0]           frame_checksum
);

  localparam logic [11:0] W_EXP = 12'(IMG_WIDTH);
  localparam logic [11:0] H_EXP = 12'(IMG_HEIGHT);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2
  } state_t;

  // Saturating increment for the 12-bit run and line counters.
  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  state_t      state_q, state_d;
  // Previous-cycle vs/de samples used for edge detection.
  logic        vs_prev_q, de_prev_q;
  logic [11:0] run_q, run_d;
  logic [11:0] lines_q, lines_d;
  logic        werr_q, werr_d;
  logic [11:0] bad_q, bad_d;
  logic        stray_q, stray_d;

  logic        frame_done_q, frame_done_d;
  logic        frame_ok_q, frame_ok_d;
  logic        err_width_q, err_width_d;
  logic        err_height_q, err_height_d;
  logic        err_stray_q, err_stray_d;
  logic [11:0] line_count_q, line_count_d;
  logic [11:0] bad_line_width_q, bad_line_width_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        report;
  logic        line_end;

`ifdef VFM_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
  logic [31:0] frame_checksum_q, frame_checksum_d;
`else
  logic        data_unused;
  assign data_unused = ^video_data;
`endif

  // Next-state, accumulator and report logic.
  always_comb begin
    state_d          = state_q;
    run_d            = run_q;
    lines_d          = lines_q;
    werr_d           = werr_q;
    bad_d            = bad_q;
    stray_d          = stray_q;
    report           = 1'b0;
    line_end         = 1'b0;
    frame_done_d     = 1'b0;
    frame_ok_d       = frame_ok_q;
    err_width_d      = err_width_q;
    err_height_d     = err_height_q;
    err_stray_d      = err_stray_q;
    line_count_d     = line_count_q;
    bad_line_width_d = bad_line_width_q;
    frame_count_d    = frame_count_q;
`ifdef VFM_CHECKSUM_EN
    sum_d            = sum_q;
    frame_checksum_d = frame_checksum_q;
`endif

    case (state_q)
      S_SYNC: begin
        // Discard whatever frame was in progress when reset released.
        if (!video_vs) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (video_de && !video_vs) stray_d = 1'b1;
        if (video_vs && !vs_prev_q) begin
          state_d = S_FRAME;
          run_d   = '0;
          lines_d = '0;
          werr_d  = 1'b0;
          bad_d   = '0;
`ifdef VFM_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      S_FRAME: begin
        if (video_vs) begin
          if (video_de) begin
            run_d = sat_inc12(run_q);
`ifdef VFM_CHECKSUM_EN
            sum_d = sum_q + 32'(video_data);
`endif
          end else if (de_prev_q) begin
            line_end = 1'b1;
          end
        end else begin
          // vs fell: close any open line with its run so far, then report.
          state_d  = S_IDLE;
          report   = 1'b1;
          line_end = de_prev_q;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (line_end) begin
      lines_d = sat_inc12(lines_q);
      if (run_q != W_EXP) begin
        werr_d = 1'b1;
        if (!werr_q) bad_d = run_q;
      end
      run_d = '0;
    end

    if (report) begin
      frame_done_d     = 1'b1;
      err_width_d      = werr_d;
      err_height_d     = (lines_d != H_EXP);
      err_stray_d      = stray_q;
      frame_ok_d       = ~(werr_d | (lines_d != H_EXP) | stray_q);
      line_count_d     = lines_d;
      bad_line_width_d = bad_d;
      frame_count_d    = frame_count_q + 16'd1;
      stray_d          = 1'b0;
`ifdef VFM_CHECKSUM_EN
      frame_checksum_d = sum_d;
`endif
    end
  end

  // State, accumulator and result registers with synchronous reset.
  always_ff @(posedge video_clk) begin
    if (rst) begin
      state_q          <= S_SYNC;
      vs_prev_q        <= 1'b0;
      de_prev_q        <= 1'b0;
      run_q            <= '0;
      lines_q          <= '0;
      werr_q           <= 1'b0;
      bad_q            <= '0;
      stray_q          <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_ok_q       <= 1'b0;
      err_width_q      <= 1'b0;
      err_height_q     <= 1'b0;
      err_stray_q      <= 1'b0;
      line_count_q     <= '0;
      bad_line_width_q <= '0;
      frame_count_q    <= '0;
`ifdef VFM_CHECKSUM_EN
      sum_q            <= '0;
      frame_checksum_q <= '0;
`endif
    end else begin
      state_q          <= state_d;
      vs_prev_q        <= video_vs;
      de_prev_q        <= video_de;
      run_q            <= run_d;
      lines_q          <= lines_d;
      werr_q           <= werr_d;
      bad_q            <= bad_d;
      stray_q          <= stray_d;
      frame_done_q     <= frame_done_d;
      frame_ok_q       <= frame_ok_d;
      err_width_q      <= err_width_d;
      err_height_q     <= err_height_d;
      err_stray_q      <= err_stray_d;
      line_count_q     <= line_count_d;
      bad_line_width_q <= bad_line_width_d;
      frame_count_q    <= frame_count_d;
`ifdef VFM_CHECKSUM_EN
      sum_q            <= sum_d;
      frame_checksum_q <= frame_checksum_d;
`endif
    end
  end

  assign frame_done     = frame_done_q;
  assign frame_ok       = frame_ok_q;
  assign err_width      = err_width_q;
  assign err_height     = err_height_q;
  assign err_stray      = err_stray_q;
  assign line_count     = line_count_q;
  assign bad_line_width = bad_line_width_q;
  assign frame_count    = frame_count_q;
`ifdef VFM_CHECKSUM_EN
  assign frame_checksum = frame_checksum_q;
`else
  assign frame_checksum = '0;
`endif

endmodule

// File: tb/tb_video_frame_monitor.sv
// Scoreboard bench for video_frame_monitor with an 8x4 image.
module tb_video_frame_monitor;

`ifdef VFM_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        video_clk = 1'b0;
  logic        rst = 1'b1;
  logic        video_vs = 1'b0;
  logic        video_de = 1'b0;
  logic [7:0]  video_data = '0;
  logic        frame_done, frame_ok, err_width, err_height, err_stray;
  logic [11:0] line_count, bad_line_width;
  logic [15:0] frame_count;
  logic [31:0] frame_checksum;

  video_frame_monitor #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(4)) dut (
    .video_clk(video_clk), .rst(rst), .video_vs(video_vs), .video_de(video_de),
    .video_data(video_data), .frame_done(frame_done), .frame_ok(frame_ok),
    .err_width(err_width), .err_height(err_height), .err_stray(err_stray),
    .line_count(line_count), .bad_line_width(bad_line_width),
    .frame_count(frame_count), .frame_checksum(frame_checksum)
  );

  always #5 video_clk = ~video_clk;

  typedef struct {
    logic        ok, ew, eh, es;
    logic [11:0] lc, blw;
    logic [15:0] fc;
    logic [31:0] cks;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [15:0] exp_fc = '0;

  always @(posedge video_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every frame_done pops one expected report.
  always @(negedge video_clk) begin
    if (frame_done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got frame_done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency_cycle",  cyc,            e.cyc);
        chk("frame_ok",       frame_ok,       e.ok);
        chk("err_width",      err_width,      e.ew);
        chk("err_height",     err_height,     e.eh);
        chk("err_stray",      err_stray,      e.es);
        chk("line_count",     line_count,     e.lc);
        chk("bad_line_width", bad_line_width, e.blw);
        chk("frame_count",    frame_count,    e.fc);
        chk("frame_checksum", frame_checksum, e.cks);
      end
    end
  end

  task automatic tick(input logic vs, input logic de, input logic [7:0] d);
    video_vs = vs; video_de = de; video_data = d;
    @(posedge video_clk); #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge video_clk);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_ok"}, frame_ok, 0);
    chk({tag, "_err_width"}, err_width, 0);
    chk({tag, "_err_height"}, err_height, 0);
    chk({tag, "_err_stray"}, err_stray, 0);
    chk({tag, "_line_count"}, line_count, 0);
    chk({tag, "_bad_line_width"}, bad_line_width, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_frame_checksum"}, frame_checksum, 0);
  endtask

  // One frame; data = pixel index within the frame. trunc_len>0 makes the
  // last line that long with vs falling while de is still high.
  // gap = number of vs-low cycles after the frame (including the fall cycle).
  task automatic send_frame(input int nl, input int sl_idx, input int sl_len,
                            input int trunc_len, input int gap,
                            input logic ok, input logic ew, input logic eh,
                            input logic es, input int lc, input int blw,
                            input int cks);
    int   p;
    int   len;
    bit   last_trunc;
    exp_t e;
    p = 0;
    tick(1'b1, 1'b0, 8'd0);
    if (nl == 0) begin
      tick(1'b1, 1'b0, 8'd0);
      tick(1'b1, 1'b0, 8'd0);
    end
    for (int l = 0; l < nl; l++) begin
      len = (l == sl_idx) ? sl_len : 8;
      last_trunc = (trunc_len > 0) && (l == nl - 1);
      if (last_trunc) len = trunc_len;
      for (int i = 0; i < len; i++) begin
        tick(1'b1, 1'b1, 8'(p));
        p++;
      end
      if (!last_trunc) begin
        tick(1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b0, 8'd0);
      end
    end
    exp_fc = exp_fc + 16'd1;
    e.ok = ok; e.ew = ew; e.eh = eh; e.es = es;
    e.lc = 12'(lc); e.blw = 12'(blw); e.fc = exp_fc;
    e.cks = CK_EN ? 32'(cks) : 32'd0;
    e.cyc = cyc + 1;
    sb.push_back(e);
    tick(1'b0, trunc_len > 0, 8'hFF);
    for (int g = 1; g < gap; g++) tick(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick(1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 8'd0);
    check_zero("reset");

    // Reset released mid-frame: the partial frame must not be reported.
    tick(1'b1, 1'b0, 8'd0);
    tick(1'b1, 1'b1, 8'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 8'd9);
    tick(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 8'd9);
    tick(1'b1, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 8'd0);
    tick(1'b0, 1'b0, 8'd0);

    //         nl sl sll tr gap ok ew eh es lc blw cks
    send_frame(4, -1, 0, 0, 3, 1, 0, 0, 0, 4, 0, 496);   // clean, checksum 0..31
    send_frame(4,  1, 7, 0, 3, 0, 1, 0, 0, 4, 7, 465);   // line 2 short
    send_frame(5, -1, 0, 0, 3, 0, 0, 1, 0, 5, 0, 780);   // extra line
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'd0);  // stray de
    tick(1'b0, 1'b0, 8'd0);
    send_frame(4, -1, 0, 0, 3, 0, 0, 0, 1, 4, 0, 496);   // reports the stray
    send_frame(4, -1, 0, 0, 1, 1, 0, 0, 0, 4, 0, 496);   // clean, 1-cycle gap
    send_frame(4, -1, 0, 5, 2, 0, 1, 0, 0, 4, 5, 406);   // truncated last line
    send_frame(0, -1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 0);     // zero-line frame
    send_frame(4, -1, 0, 0, 3, 1, 0, 0, 0, 4, 0, 496);   // clean

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1'b0, 1'b0, 8'd0);
    chk("scoreboard_drained", sb.size(), 0);

    // Reset in the middle of a frame: no report, all outputs cleared.
    tick(1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'd3);
    rst = 1'b1;
    exp_fc = '0;
    tick(1'b1, 1'b1, 8'd3);
    tick(1'b0, 1'b0, 8'd0);
    check_zero("midreset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

endmodule
